// File: rtl/dpmem_port_arbiter.sv
// Round-robin arbiter that shares one DualPortMemory port among NREQ requesters.
// Accepted accesses drive the memory port from registers; read data returns two edges later.
module dpmem_port_arbiter #(
  parameter int NREQ        = 4,
  parameter int SIZEDATA    = 32,
  parameter int SIZEADDRESS = 16,
  parameter int MAX_BURST   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ-1:0]               lock,
  input  logic [NREQ-1:0]               we,
  input  logic [NREQ*SIZEADDRESS-1:0]   addr,
  input  logic [NREQ*SIZEDATA-1:0]      wdata,
  output logic [NREQ-1:0]               gnt,
  output logic [NREQ-1:0]               rvalid,
  output logic [SIZEDATA-1:0]           rdata,
  output logic                          mem_enable,
  output logic                          mem_write,
  output logic [SIZEADDRESS-1:0]        mem_address,
  output logic [SIZEDATA-1:0]           mem_datain,
  input  logic [SIZEDATA-1:0]           mem_dataout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [PW-1:0] IDX_LAST   = PW'(NREQ - 1);
  localparam logic [PW:0]   NREQ_EXT   = (PW+1)'(NREQ);

  logic [SIZEADDRESS-1:0] w_addr_arr  [NREQ];
  logic [SIZEDATA-1:0]    w_wdata_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = addr[gi*SIZEADDRESS +: SIZEADDRESS];
    assign w_wdata_arr[gi] = wdata[gi*SIZEDATA +: SIZEDATA];
  end

  logic [PW-1:0]       r_ptr;
  logic [BW-1:0]       r_burst_cnt;
  logic                r_mem_enable;
  logic                r_mem_write;
  logic [SIZEADDRESS-1:0] r_mem_address;
  logic [SIZEDATA-1:0] r_mem_datain;
  logic                r_rd_pend1;
  logic [PW-1:0]       r_rd_tag1;
  logic                r_rd_pend2;
  logic [PW-1:0]       r_rd_tag2;
  logic [NREQ-1:0]     r_rvalid;
  logic [SIZEDATA-1:0] r_rdata;

  logic [NREQ-1:0]     w_gnt;
  logic [PW-1:0]       w_idx;
  logic                w_found;
  logic                w_xfer;
  logic [PW:0]         w_sum;
  logic [PW-1:0]       w_cand;

  // Rotating priority search: first requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_gnt   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_sum >= NREQ_EXT) begin
        w_sum = w_sum - NREQ_EXT;
      end
      w_cand = w_sum[PW-1:0];
      if (!w_found && req[w_cand]) begin
        w_found       = 1'b1;
        w_idx         = w_cand;
        w_gnt[w_cand] = 1'b1;
      end
    end
  end

  assign w_xfer = w_found & rst_n;
  assign gnt    = w_gnt & {NREQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr         <= '0;
      r_burst_cnt   <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_datain  <= '0;
      r_rd_pend1    <= 1'b0;
      r_rd_tag1     <= '0;
      r_rd_pend2    <= 1'b0;
      r_rd_tag2     <= '0;
      r_rvalid      <= '0;
      r_rdata       <= '0;
    end else begin
      r_mem_enable <= w_xfer;
      r_rd_pend1   <= w_xfer & ~we[w_idx];
      // Second stage tracks the edge at which the memory itself samples the read.
      r_rd_pend2   <= r_rd_pend1;
      r_rd_tag2    <= r_rd_tag1;
      r_rvalid     <= '0;
      if (r_rd_pend2) begin
        r_rvalid[r_rd_tag2] <= 1'b1;
        r_rdata             <= mem_dataout;
      end
      if (w_xfer) begin
        r_mem_write   <= we[w_idx];
        r_mem_address <= w_addr_arr[w_idx];
        r_mem_datain  <= w_wdata_arr[w_idx];
        r_rd_tag1     <= w_idx;
        if (lock[w_idx] && (r_burst_cnt < BURST_LAST)) begin
          r_ptr       <= w_idx;
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end else begin
          r_ptr       <= (w_idx == IDX_LAST) ? '0 : w_idx + 1'b1;
          r_burst_cnt <= '0;
        end
      end else begin
        r_mem_write <= 1'b0;
      end
    end
  end

  assign mem_enable  = r_mem_enable;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_datain  = r_mem_datain;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;

endmodule
